ex_mem_buffer: RTL and testbench



---
 rtl/ex_mem_buffer.sv | 175 +++++++++++++++++
 tb/tb_ex_mem_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// Purpose: EX->MEM pipeline buffer capturing ALU outputs, control bits and resolved branch decision.
// Latency: entry accepted at edge N is on mem_* in cycle N+1 (empty, or one entry with same-cycle pop).
// Backpressure: 2-entry skid buffer; ex_ready_o comes from registered state only, never from mem_ready_i.
//
// Ports: clk_i/rst_i (sync active-high), flush_i; ex_* / alu_* / control inputs from execute;
//        mem_valid_o/mem_ready_i handshake with mem_* head-entry fields, branch_taken_o, ovf_trap_o;
//        stall_cnt_o saturating count of stalled cycles.
// Optional feature: define EXMEM_OVF_TRAP_EN to trap (and suppress commits of) overflowing writes.
module ex_mem_buffer #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_overflow_i,
    input  logic              alu_cout_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] pc_branch_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] mem_result_o,
    output logic [DATA_W-1:0] mem_store_data_o,
    output logic [DATA_W-1:0] mem_pc_branch_o,
    output logic [RD_W-1:0]   mem_rd_addr_o,
    output logic              mem_reg_write_o,
    output logic              mem_mem_read_o,
    output logic              mem_mem_write_o,
    output logic              mem_cout_o,
    output logic              branch_taken_o,
    output logic              ovf_trap_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] pc_branch;
        logic [RD_W-1:0]   rd_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              cout;
        logic              branch_taken;
        logic              ovf_trap;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           head_q, skid_q, in_ent;
    logic [CNT_W-1:0] stall_q;
    logic             push, pop;
    logic             head_ld_in, head_ld_skid, skid_ld;
    logic             commit_ok;

    assign ex_ready_o  = !rst_i && (state_q != TWO);
    assign mem_valid_o = (state_q != EMPTY);
    assign push        = ex_valid_i && ex_ready_o;
    assign pop         = mem_valid_o && mem_ready_i;

    // Branch is resolved once, at capture, so the memory stage sees a stable decision.
    always_comb begin
        in_ent              = '0;
        in_ent.result       = alu_result_i;
        in_ent.store_data   = store_data_i;
        in_ent.pc_branch    = pc_branch_i;
        in_ent.rd_addr      = rd_addr_i;
        in_ent.reg_write    = reg_write_i;
        in_ent.mem_read     = mem_read_i;
        in_ent.mem_write    = mem_write_i;
        in_ent.cout         = alu_cout_i;
        in_ent.branch_taken = branch_i && (alu_zero_i ^ branch_ne_i);
`ifdef EXMEM_OVF_TRAP_EN
        in_ent.ovf_trap     = alu_overflow_i && reg_write_i;
`else
        in_ent.ovf_trap     = 1'b0;
`endif
    end

`ifndef EXMEM_OVF_TRAP_EN
    // Overflow has no effect in this build.
    logic unused_ovf;
    assign unused_ovf = alu_overflow_i;
`endif

    // Next-state / load-enable logic. Flush overrides both push and pop.
    always_comb begin
        state_d      = state_q;
        head_ld_in   = 1'b0;
        head_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d    = ONE;
                        head_ld_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_ld_in = 1'b1;
                    end else if (push) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d      = ONE;
                        head_ld_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (head_ld_in) begin
                head_q <= in_ent;
            end else if (head_ld_skid) begin
                head_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= in_ent;
            end
            if (mem_valid_o && !mem_ready_i && !flush_i && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    // A trapped entry must never commit: suppress its register and memory side effects.
    assign commit_ok        = mem_valid_o && !head_q.ovf_trap;
    assign mem_result_o     = head_q.result;
    assign mem_store_data_o = head_q.store_data;
    assign mem_pc_branch_o  = head_q.pc_branch;
    assign mem_rd_addr_o    = head_q.rd_addr;
    assign mem_cout_o       = head_q.cout;
    assign mem_reg_write_o  = head_q.reg_write && commit_ok;
    assign mem_mem_read_o   = head_q.mem_read && commit_ok;
    assign mem_mem_write_o  = head_q.mem_write && commit_ok;
    assign branch_taken_o   = head_q.branch_taken && mem_valid_o;
    assign ovf_trap_o       = head_q.ovf_trap && mem_valid_o;
    assign stall_cnt_o      = stall_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Purpose: self-checking bench for ex_mem_buffer against a queue-based reference model.
// Latency: model updates at each rising edge; outputs sampled 1 time unit later.
// Backpressure: model accepts while it holds fewer than two entries and reset is low.
module tb_ex_mem_buffer;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, flush_i = 1'b0, ex_valid_i = 1'b0, mem_ready_i = 1'b0;
    logic [DW-1:0] alu_result_i = '0, store_data_i = '0, pc_branch_i = '0;
    logic          alu_zero_i = 1'b0, alu_overflow_i = 1'b0, alu_cout_i = 1'b0;
    logic [RW-1:0] rd_addr_i = '0;
    logic          reg_write_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic          branch_i = 1'b0, branch_ne_i = 1'b0;
    logic          ex_ready_o, mem_valid_o;
    logic [DW-1:0] mem_result_o, mem_store_data_o, mem_pc_branch_o;
    logic [RW-1:0] mem_rd_addr_o;
    logic          mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_cout_o;
    logic          branch_taken_o, ovf_trap_o;
    logic [CW-1:0] stall_cnt_o;

    int n_cmp = 0;
    int n_fail = 0;

    ex_mem_buffer #(.DATA_W(DW), .RD_W(RW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .alu_overflow_i(alu_overflow_i), .alu_cout_i(alu_cout_i),
        .store_data_i(store_data_i), .pc_branch_i(pc_branch_i), .rd_addr_i(rd_addr_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .branch_i(branch_i), .branch_ne_i(branch_ne_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_result_o(mem_result_o), .mem_store_data_o(mem_store_data_o),
        .mem_pc_branch_o(mem_pc_branch_o), .mem_rd_addr_o(mem_rd_addr_o),
        .mem_reg_write_o(mem_reg_write_o), .mem_mem_read_o(mem_mem_read_o),
        .mem_mem_write_o(mem_mem_write_o), .mem_cout_o(mem_cout_o),
        .branch_taken_o(branch_taken_o), .ovf_trap_o(ovf_trap_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of at most two captured entries.
    typedef struct {
        logic [DW-1:0] result, store_data, pc_branch;
        logic [RW-1:0] rd;
        logic rw, mr, mw, cout, bt, ovf;
    } ent_t;

    ent_t q[$];
    int   stall_m = 0;

    function automatic ent_t capture();
        ent_t e;
        e.result = alu_result_i; e.store_data = store_data_i; e.pc_branch = pc_branch_i;
        e.rd = rd_addr_i; e.rw = reg_write_i; e.mr = mem_read_i; e.mw = mem_write_i;
        e.cout = alu_cout_i;
        e.bt = branch_i && (alu_zero_i != branch_ne_i);
`ifdef EXMEM_OVF_TRAP_EN
        e.ovf = alu_overflow_i && reg_write_i;
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic tick();
        bit can_take;
        @(posedge clk);
        can_take = !rst_i && (q.size() < 2);
        if (rst_i) begin
            q.delete();
            stall_m = 0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !mem_ready_i && stall_m < (1 << CW) - 1) stall_m++;
            if (q.size() > 0 && mem_ready_i) void'(q.pop_front());
            if (ex_valid_i && can_take) q.push_back(capture());
        end
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 0; ex_valid_i = 0; mem_ready_i = 0; alu_result_i = '0; store_data_i = '0;
        pc_branch_i = '0; rd_addr_i = '0; alu_zero_i = 0; alu_overflow_i = 0; alu_cout_i = 0;
        reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; branch_i = 0; branch_ne_i = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        ex_valid_i = 1; alu_result_i = 64'hDEAD; reg_write_i = 1; mem_ready_i = 1;
        tick();                       // entry pushed before reset
        rst_i = 1; alu_result_i = 64'hBEEF;
        tick();                       // reset edge with a push offered
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_valid_o); end
        n_cmp++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", ex_ready_o); end
        n_cmp++; if (mem_result_o !== '0 || mem_reg_write_o !== 1'b0 || branch_taken_o !== 1'b0 || ovf_trap_o !== 1'b0)
            begin n_fail++; $display("FAIL reset_outputs: result %h rw %b bt %b ovf %b want all 0", mem_result_o, mem_reg_write_o, branch_taken_o, ovf_trap_o); end
        n_cmp++; if (stall_cnt_o !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt_o); end
        rst_i = 0; ex_valid_i = 0;
        #1;
        n_cmp++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", ex_ready_o); end
        tick();
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_no_ghost: got %b want 0", mem_valid_o); end
    endtask

    task automatic test_single();
        apply_reset();
        ex_valid_i = 1; alu_result_i = 64'h0000_0000_0000_0005; reg_write_i = 1; mem_ready_i = 1;
        tick();
        ex_valid_i = 0;
        n_cmp++; if (mem_valid_o !== 1'b1 || mem_result_o !== 64'd5) begin n_fail++; $display("FAIL single_out: valid %b result %h want 1 / 5", mem_valid_o, mem_result_o); end
        n_cmp++; if (mem_reg_write_o !== 1'b1) begin n_fail++; $display("FAIL single_rw: got %b want 1", mem_reg_write_o); end
        tick();
        n_cmp++; if (mem_valid_o !== 1'b0 || mem_reg_write_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: valid %b rw %b want 0 0", mem_valid_o, mem_reg_write_o); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] want [3];
        want[0] = 64'd1; want[1] = 64'd2; want[2] = 64'd3;
        apply_reset();
        mem_ready_i = 0; ex_valid_i = 1;
        alu_result_i = 64'd1; tick();
        alu_result_i = 64'd2; tick();
        alu_result_i = 64'd3;
        n_cmp++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", ex_ready_o); end
        tick();
        n_cmp++; if (stall_cnt_o !== 4'd2) begin n_fail++; $display("FAIL bp_stall: got %0d want 2", stall_cnt_o); end
        mem_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_valid_o !== 1'b1 || mem_result_o !== want[i])
                begin n_fail++; $display("FAIL bp_order[%0d]: valid %b result %0d want 1 / %0d", i, mem_valid_o, mem_result_o, want[i]); end
            tick();
            if (i == 1) ex_valid_i = 0;
        end
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", mem_valid_o); end
    endtask

    task automatic test_branch();
        // {branch, branch_ne, zero, expected taken}
        logic [3:0] cases [5];
        cases[0] = 4'b1011; cases[1] = 4'b1110; cases[2] = 4'b0010; cases[3] = 4'b1101; cases[4] = 4'b1000;
        apply_reset();
        mem_ready_i = 1;
        foreach (cases[i]) begin
            logic [3:0] c;
            c = cases[i];
            branch_i = c[3]; branch_ne_i = c[2]; alu_zero_i = c[1]; ex_valid_i = 1;
            tick();
            ex_valid_i = 0; branch_i = 0; branch_ne_i = 0; alu_zero_i = 0;
            n_cmp++; if (branch_taken_o !== c[0]) begin n_fail++; $display("FAIL branch[%0d]: got %b want %b", i, branch_taken_o, c[0]); end
            tick();
        end
    endtask

    task automatic test_flush();
        apply_reset();
        mem_ready_i = 0; ex_valid_i = 1;
        alu_result_i = 64'hA; tick();
        alu_result_i = 64'hB; tick();
        alu_result_i = 64'hC; flush_i = 1;
        tick();
        flush_i = 0;
        n_cmp++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_two: valid %b ready %b want 0 1", mem_valid_o, ex_ready_o); end
        n_cmp++; if (stall_cnt_o !== 4'd1) begin n_fail++; $display("FAIL flush_stall_hold: got %0d want 1", stall_cnt_o); end
        ex_valid_i = 0; mem_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got valid %b want 0", i, mem_valid_o); end
        end
        // Flush in EMPTY with a push offered discards the push.
        ex_valid_i = 1; flush_i = 1; alu_result_i = 64'hD;
        tick();
        ex_valid_i = 0; flush_i = 0;
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_push: got valid %b want 0", mem_valid_o); end
    endtask

    task automatic test_overflow();
        apply_reset();
        mem_ready_i = 1; ex_valid_i = 1; alu_overflow_i = 1; reg_write_i = 1; mem_read_i = 1;
        tick();
        ex_valid_i = 0; alu_overflow_i = 0;
`ifdef EXMEM_OVF_TRAP_EN
        n_cmp++; if (ovf_trap_o !== 1'b1 || mem_reg_write_o !== 1'b0 || mem_mem_read_o !== 1'b0)
            begin n_fail++; $display("FAIL ovf_trap: ovf %b rw %b mr %b want 1 0 0", ovf_trap_o, mem_reg_write_o, mem_mem_read_o); end
`else
        n_cmp++; if (ovf_trap_o !== 1'b0 || mem_reg_write_o !== 1'b1 || mem_mem_read_o !== 1'b1)
            begin n_fail++; $display("FAIL ovf_pass: ovf %b rw %b mr %b want 0 1 1", ovf_trap_o, mem_reg_write_o, mem_mem_read_o); end
`endif
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        ex_valid_i = 1; mem_ready_i = 0;
        tick();
        ex_valid_i = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 9) begin
                n_cmp++; if (stall_cnt_o !== 4'd9) begin n_fail++; $display("FAIL sat_mid: got %0d want 9", stall_cnt_o); end
            end
        end
        n_cmp++; if (stall_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_top: got %0d want 15", stall_cnt_o); end
    endtask

    task automatic test_random();
        int fails_before;
        fails_before = n_fail;
        apply_reset();
        stall_m = 0;
        for (int n = 0; n < 400; n++) begin
            ent_t h;
            bit   v;
            rst_i          = ($urandom_range(99) < 2);
            flush_i        = ($urandom_range(99) < 4);
            ex_valid_i     = ($urandom_range(99) < 70);
            mem_ready_i    = ($urandom_range(99) < 55);
            alu_result_i   = {$urandom, $urandom};
            store_data_i   = {$urandom, $urandom};
            pc_branch_i    = {$urandom, $urandom};
            rd_addr_i      = RW'($urandom);
            {alu_zero_i, alu_overflow_i, alu_cout_i, reg_write_i} = 4'($urandom);
            {mem_read_i, mem_write_i, branch_i, branch_ne_i}     = 4'($urandom);
            tick();
            v = (q.size() > 0);
            n_cmp++; if (mem_valid_o !== v) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", n, mem_valid_o, v); end
            n_cmp++; if (ex_ready_o !== (!rst_i && q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", n, ex_ready_o, (!rst_i && q.size() < 2)); end
            n_cmp++; if (stall_cnt_o !== CW'(stall_m)) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d want %0d", n, stall_cnt_o, stall_m); end
            if (v) begin
                h = q[0];
                n_cmp++;
                if (mem_result_o !== h.result || mem_store_data_o !== h.store_data ||
                    mem_pc_branch_o !== h.pc_branch || mem_rd_addr_o !== h.rd || mem_cout_o !== h.cout)
                    begin n_fail++; $display("FAIL rnd_data@%0d: got result %h rd %0d want %h %0d", n, mem_result_o, mem_rd_addr_o, h.result, h.rd); end
                n_cmp++;
                if (mem_reg_write_o !== (h.rw && !h.ovf) || mem_mem_read_o !== (h.mr && !h.ovf) ||
                    mem_mem_write_o !== (h.mw && !h.ovf) || branch_taken_o !== h.bt || ovf_trap_o !== h.ovf)
                    begin n_fail++; $display("FAIL rnd_ctrl@%0d: got rw%b mr%b mw%b bt%b ovf%b want rw%b mr%b mw%b bt%b ovf%b", n,
                        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, branch_taken_o, ovf_trap_o,
                        h.rw && !h.ovf, h.mr && !h.ovf, h.mw && !h.ovf, h.bt, h.ovf); end
            end else begin
                n_cmp++;
                if ({mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, branch_taken_o, ovf_trap_o} !== 5'b0)
                    begin n_fail++; $display("FAIL rnd_idle_ctrl@%0d: got %b want 00000", n,
                        {mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, branch_taken_o, ovf_trap_o}); end
            end
            if (n_fail - fails_before > 20) break;
        end
        clear_inputs();
        rst_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_i = 1;
        tick();
        rst_i = 0;
        test_reset();
        test_single();
        test_back_pressure();
        test_branch();
        test_flush();
        test_overflow();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
